// File: rtl/score_keeper.sv
// Score keeper: BCD score, lives and session high score under a PLAY/WIN/OVER
// state machine, with active-low seven-segment outputs and a respawn pulse.
module score_keeper #(
    parameter int WIN_SCORE = 10,
    parameter int LIVES     = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_point,
    input  logic       i_death,
    input  logic       i_start,
    output logic [6:0] o_hex0,
    output logic [6:0] o_hex1,
    output logic [6:0] o_hex2,
    output logic [6:0] o_hex3,
    output logic [1:0] o_lives,
    output logic       o_win,
    output logic       o_game_over,
    output logic       o_respawn
);

    localparam logic [3:0] WIN_TENS   = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_ONES   = 4'(WIN_SCORE % 10);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [3:0] r_hiOnes;
    logic [3:0] r_hiTens;
    logic [1:0] r_lives;
    logic       r_win;
    logic       r_gameOver;
    logic       r_respawn;

    logic [3:0] w_nextOnes;
    logic [3:0] w_nextTens;
    logic       w_nextIsWin;
    logic       w_nextBeatsHigh;
    logic       w_curBeatsHigh;

    always_comb begin
        w_nextOnes = r_ones + 4'd1;
        w_nextTens = r_tens;
        if (r_ones == 4'd9) begin
            w_nextOnes = 4'd0;
            w_nextTens = r_tens + 4'd1;
        end
        w_nextIsWin     = (w_nextTens == WIN_TENS) && (w_nextOnes == WIN_ONES);
        // Concatenated BCD digits compare correctly as plain binary, tens first.
        w_nextBeatsHigh = {w_nextTens, w_nextOnes} > {r_hiTens, r_hiOnes};
        w_curBeatsHigh  = {r_tens, r_ones} > {r_hiTens, r_hiOnes};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= PLAY;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_hiOnes   <= 4'd0;
            r_hiTens   <= 4'd0;
            r_lives    <= LIVES_INIT;
            r_win      <= 1'b0;
            r_gameOver <= 1'b0;
            r_respawn  <= 1'b0;
        end else begin
            r_respawn <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (i_point) begin
                        r_ones    <= w_nextOnes;
                        r_tens    <= w_nextTens;
                        r_respawn <= 1'b1;
                        if (w_nextIsWin) begin
                            r_state <= WIN;
                            r_win   <= 1'b1;
                            if (w_nextBeatsHigh) begin
                                r_hiOnes <= w_nextOnes;
                                r_hiTens <= w_nextTens;
                            end
                        end
                    end else if (i_death) begin
                        r_lives   <= r_lives - 2'd1;
                        r_respawn <= 1'b1;
                        if (r_lives == 2'd1) begin
                            r_state    <= OVER;
                            r_gameOver <= 1'b1;
                            if (w_curBeatsHigh) begin
                                r_hiOnes <= r_ones;
                                r_hiTens <= r_tens;
                            end
                        end
                    end
                end
                WIN, OVER: begin
                    if (i_start) begin
                        r_state    <= PLAY;
                        r_ones     <= 4'd0;
                        r_tens     <= 4'd0;
                        r_lives    <= LIVES_INIT;
                        r_win      <= 1'b0;
                        r_gameOver <= 1'b0;
                        r_respawn  <= 1'b1;
                    end
                end
                default: r_state <= PLAY;
            endcase
        end
    end

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        case (digit)
            4'd0:    segDecode = 7'b1000000;
            4'd1:    segDecode = 7'b1111001;
            4'd2:    segDecode = 7'b0100100;
            4'd3:    segDecode = 7'b0110000;
            4'd4:    segDecode = 7'b0011001;
            4'd5:    segDecode = 7'b0010010;
            4'd6:    segDecode = 7'b0000010;
            4'd7:    segDecode = 7'b1111000;
            4'd8:    segDecode = 7'b0000000;
            4'd9:    segDecode = 7'b0010000;
            default: segDecode = 7'b1111111;
        endcase
    endfunction

    assign o_hex0      = segDecode(r_ones);
    assign o_hex1      = segDecode(r_tens);
    assign o_hex2      = segDecode(r_hiOnes);
    assign o_hex3      = segDecode(r_hiTens);
    assign o_lives     = r_lives;
    assign o_win       = r_win;
    assign o_game_over = r_gameOver;
    assign o_respawn   = r_respawn;

endmodule

// File: doc/score_keeper.md
# score_keeper

Downstream consumer of the top-row point detector's one-cycle `point` pulse and the collision logic's `death` pulse. It keeps the two-digit BCD score, remaining lives and session high score, and runs the PLAY/WIN/OVER game state machine. It drives four active-low seven-segment displays and requests a frog respawn after every scored point or death.

## Interface
- `WIN_SCORE`, default 10: score (1..99) that ends the game as a win.
- `LIVES`, default 3: starting lives (1..3).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge `clk`).
- `point`  in  1  one-cycle pulse from the point detector; frog reached the final row.
- `death`  in  1  one-cycle pulse; frog collided or fell.
- `start`  in  1  level; restarts a new game from WIN or OVER.
- `hex0`  out  7  score ones digit, active-low, bit order gfedcba.
- `hex1`  out  7  score tens digit, same encoding.
- `hex2`  out  7  high-score ones digit.
- `hex3`  out  7  high-score tens digit.
- `lives`  out  2  remaining lives.
- `win`  out  1  high while in WIN.
- `game_over`  out  1  high while in OVER.
- `respawn`  out  1  one-cycle pulse; frog logic returns frog to start row.

## Operation
- State machine with three states:
  - PLAY: normal counting.
  - WIN: score reached `WIN_SCORE`.
  - OVER: lives exhausted.
- PLAY, `point`=1:
  - BCD increment. Ones 9→0 with tens+1, otherwise ones+1.
  - If the new score equals `WIN_SCORE`, go to WIN; otherwise stay in PLAY.
  - `respawn` is pulsed in both cases.
- PLAY, `death`=1 with `point`=0:
  - `lives`−1 and `respawn` pulsed.
  - If `lives` was 1, `lives` becomes 0 and the state goes to OVER.
- PLAY, `point` and `death` in the same cycle: `point` wins and `death` is ignored (frog already scored).
- WIN/OVER: `point` and `death` are ignored; score and lives are frozen.
- WIN/OVER, `start`=1:
  - Score becomes 00 and `lives` becomes `LIVES`.
  - Go to PLAY and pulse `respawn` once.
  - `start` is ignored in PLAY.
- High score:
  - On the transition into WIN or OVER, if the final score > high score (two-digit BCD compare, tens first), the high score takes the final score.
  - Reset clears the high score to 00. `start` does not clear it.
- Score never exceeds `WIN_SCORE`, so 99 overflow cannot occur. The tens digit is limited to 0..9.
- Hex decode:
  - Combinational from the registered digits: 0→1000000, 1→1111001, …, 9→0010000.
  - Codes 10..15 display blank (1111111).

## Timing
- While `reset`=0 at posedge (values hold the cycle after):
  - State PLAY, score 00, high 00, `lives`=`LIVES`.
  - `win`=0, `game_over`=0, `respawn`=0.
  - `hex0`..`hex3`=1000000.
- Reset dominates all inputs, including mid-game and in WIN/OVER.
- Latency from a `point`/`death` pulse in cycle N:
  - Score and lives update at posedge ending N, visible in N+1.
  - `respawn` is high for exactly cycle N+1.
  - `win`/`game_over` are high from N+1.
- Hex outputs follow the registered digits in the same cycle (no extra delay).
- High score updates in the same cycle the state enters WIN/OVER.
- Held `start`: one restart per WIN/OVER entry. After returning to PLAY, `start` is ignored.
- Back-to-back `point` pulses in consecutive cycles each count. The upstream detector guarantees this never happens, but the block must not lose counts.

## Test plan
- Reset then 3 `point` pulses spaced 4 cycles apart → score 03, `hex0`=0110000, `hex1`=1000000, `respawn` one cycle after each pulse.
- 9 `point` pulses then 1 more with `WIN_SCORE`=10 → score 09 then 10, `hex1`=1111001 and `hex0`=1000000, `win`=1 in the cycle after the 10th pulse, high score 10. A further `point` leaves the score at 10.
- 3 `death` pulses with `LIVES`=3 → `lives` 2,1,0, `game_over`=1 after the third, 3 `respawn` pulses; the next `death` and `point` are ignored.
- `point` and `death` asserted together in PLAY with score 05, lives 3 → score 06, lives 3, single `respawn`.
- From OVER with score 04 and high 07, assert `start` → score 00, lives 3, high stays 07, PLAY. A later OVER at score 08 → high 08.
- Mid-game (score 06, lives 1), drive `reset`=0 for one cycle → score 00, high 00, lives 3, all flags 0 the next cycle.
